// File: rtl/alu_reservation_station.sv
// Integer-ALU reservation station: holds micro-ops until both operands are ready, snoops the CDB for wakeup
// and issues the lowest-index ready entry one edge after it is selectable; dispatch backpressures via disp_ready.
package alu_rs_pkg;
   typedef struct packed {
      logic [3:0]  op;
      logic [5:0]  phys_rd;
      logic [31:0] rs1_v;
      logic [31:0] rs2_v;
   } functional_unit_t;
endpackage

module alu_reservation_station
   import alu_rs_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int PHYS_W = 6,
   parameter int CNT_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    disp_valid,
   output logic                    disp_ready,
   input  functional_unit_t        disp_uop,
   input  logic [PHYS_W-1:0]       disp_rs1_s,
   input  logic [PHYS_W-1:0]       disp_rs2_s,
   input  logic                    disp_rs1_rdy,
   input  logic                    disp_rs2_rdy,
   input  logic                    cdb_valid,
   input  logic [PHYS_W-1:0]       cdb_phys_rd,
   input  logic [31:0]             cdb_data,
   input  logic                    issue_stall,
   output logic                    issue_start,
   output functional_unit_t        issue_uop,
   output logic [CNT_W-1:0]        occupancy
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DEPTH-1:0]  ent_valid;
   logic [DEPTH-1:0]  ent_rs1_rdy;
   logic [DEPTH-1:0]  ent_rs2_rdy;
   functional_unit_t  ent_uop   [DEPTH];
   logic [PHYS_W-1:0] ent_rs1_s [DEPTH];
   logic [PHYS_W-1:0] ent_rs2_s [DEPTH];

   logic [DEPTH-1:0]  cand;
   logic [IDX_W-1:0]  free_idx;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_found;
   logic              disp_fire;
   logic              issue_fire;
   logic              cdb_wake;
   logic [DEPTH-1:0]  issue_clr;
   logic [DEPTH-1:0]  disp_set;
   functional_unit_t  disp_ent;
   logic              d_rs1_rdy;
   logic              d_rs2_rdy;

   assign cand       = ent_valid & ent_rs1_rdy & ent_rs2_rdy;
   assign sel_found  = |cand;
   assign disp_ready = ~&ent_valid;
   assign disp_fire  = disp_valid && disp_ready && !flush;
   assign issue_fire = !issue_stall && sel_found;
   assign cdb_wake   = cdb_valid && (cdb_phys_rd != '0);

   // Descending scan so the lowest index is the last (winning) assignment.
   always_comb begin
      free_idx = '0;
      sel_idx  = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!ent_valid[i]) free_idx = IDX_W'(i);
         if (cand[i])       sel_idx  = IDX_W'(i);
      end
   end

   always_comb begin
      issue_clr = '0;
      disp_set  = '0;
      if (issue_fire) issue_clr[sel_idx]  = 1'b1;
      if (disp_fire)  disp_set[free_idx]  = 1'b1;
   end

   // Tag 0 is the hardwired zero register; otherwise bypass a same-cycle CDB hit.
   always_comb begin
      disp_ent  = disp_uop;
      d_rs1_rdy = disp_rs1_rdy;
      d_rs2_rdy = disp_rs2_rdy;
      if (disp_rs1_s == '0) begin
         d_rs1_rdy      = 1'b1;
         disp_ent.rs1_v = '0;
      end else if (!disp_rs1_rdy && cdb_wake && (cdb_phys_rd == disp_rs1_s)) begin
         d_rs1_rdy      = 1'b1;
         disp_ent.rs1_v = cdb_data;
      end
      if (disp_rs2_s == '0) begin
         d_rs2_rdy      = 1'b1;
         disp_ent.rs2_v = '0;
      end else if (!disp_rs2_rdy && cdb_wake && (cdb_phys_rd == disp_rs2_s)) begin
         d_rs2_rdy      = 1'b1;
         disp_ent.rs2_v = cdb_data;
      end
   end

   // Entry payload needs no reset: it is only observed through ent_valid.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (cdb_wake && ent_valid[i] && !ent_rs1_rdy[i] && (ent_rs1_s[i] == cdb_phys_rd)) begin
            ent_rs1_rdy[i]    <= 1'b1;
            ent_uop[i].rs1_v  <= cdb_data;
         end
         if (cdb_wake && ent_valid[i] && !ent_rs2_rdy[i] && (ent_rs2_s[i] == cdb_phys_rd)) begin
            ent_rs2_rdy[i]    <= 1'b1;
            ent_uop[i].rs2_v  <= cdb_data;
         end
      end
      if (disp_fire) begin
         ent_uop[free_idx]     <= disp_ent;
         ent_rs1_s[free_idx]   <= disp_rs1_s;
         ent_rs2_s[free_idx]   <= disp_rs2_s;
         ent_rs1_rdy[free_idx] <= d_rs1_rdy;
         ent_rs2_rdy[free_idx] <= d_rs2_rdy;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid   <= '0;
         issue_start <= 1'b0;
         issue_uop   <= '0;
         occupancy   <= '0;
      end else if (flush) begin
         ent_valid   <= '0;
         issue_start <= 1'b0;
         occupancy   <= '0;
      end else begin
         if (!issue_stall) begin
            issue_start <= sel_found;
            if (sel_found) issue_uop <= ent_uop[sel_idx];
         end
         ent_valid <= (ent_valid & ~issue_clr) | disp_set;
         occupancy <= occupancy + CNT_W'(disp_fire) - CNT_W'(issue_fire);
      end
   end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed bench for alu_reservation_station: hand-timed dispatch, wakeup, bypass, stall, flush and reset cases.
module tb_alu_reservation_station;
   import alu_rs_pkg::*;

   logic             clk = 1'b0;
   logic             rst, flush, disp_valid, disp_ready;
   functional_unit_t disp_uop, issue_uop;
   logic [5:0]       disp_rs1_s, disp_rs2_s, cdb_phys_rd;
   logic             disp_rs1_rdy, disp_rs2_rdy, cdb_valid, issue_stall, issue_start;
   logic [31:0]      cdb_data;
   logic [3:0]       occupancy;

   int n_checks = 0;
   int n_fail   = 0;

   alu_reservation_station dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_uop(disp_uop),
      .disp_rs1_s(disp_rs1_s), .disp_rs2_s(disp_rs2_s),
      .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
      .cdb_valid(cdb_valid), .cdb_phys_rd(cdb_phys_rd), .cdb_data(cdb_data),
      .issue_stall(issue_stall), .issue_start(issue_start), .issue_uop(issue_uop),
      .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_disp(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                           input logic [5:0] s1, input logic r1, input logic [5:0] s2, input logic r2);
      disp_valid   = 1'b1;
      disp_uop     = '{op: op, phys_rd: 6'd40, rs1_v: v1, rs2_v: v2};
      disp_rs1_s   = s1;
      disp_rs1_rdy = r1;
      disp_rs2_s   = s2;
      disp_rs2_rdy = r2;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_uop = '0;
      disp_rs1_s = '0; disp_rs2_s = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
      cdb_valid = 1'b0; cdb_phys_rd = '0; cdb_data = '0; issue_stall = 1'b0;
      tick(); tick();
      rst = 1'b0;
      check("rst_occ", 32'(occupancy), 0);
      check("rst_start", 32'(issue_start), 0);
      check("rst_uop", issue_uop.rs1_v | issue_uop.rs2_v, 0);
      check("rst_ready", 32'(disp_ready), 1);

      // Both sources ready: issue one edge after acceptance.
      set_disp(4'd1, 32'd5, 32'd7, 6'd1, 1'b1, 6'd2, 1'b1);
      tick(); disp_valid = 1'b0;
      check("add_occ1", 32'(occupancy), 1);
      check("add_nostart", 32'(issue_start), 0);
      tick();
      check("add_start", 32'(issue_start), 1);
      check("add_rs1", issue_uop.rs1_v, 5);
      check("add_rs2", issue_uop.rs2_v, 7);
      check("add_occ0", 32'(occupancy), 0);
      tick();
      check("add_idle", 32'(issue_start), 0);

      // rs2 waits on tag 12, woken by the CDB three cycles later.
      set_disp(4'd2, 32'd1, 32'd0, 6'd4, 1'b1, 6'd12, 1'b0);
      tick(); disp_valid = 1'b0;
      tick(); check("wake_wait1", 32'(issue_start), 0);
      tick(); check("wake_wait2", 32'(issue_start), 0);
      cdb_valid = 1'b1; cdb_phys_rd = 6'd12; cdb_data = 32'hDEADBEEF;
      tick(); cdb_valid = 1'b0;
      check("wake_edge", 32'(issue_start), 0);
      tick();
      check("wake_start", 32'(issue_start), 1);
      check("wake_rs2", issue_uop.rs2_v, 32'hDEADBEEF);
      check("wake_rs1", issue_uop.rs1_v, 1);
      tick();

      // Same-cycle bypass of rs1 tag 9.
      set_disp(4'd3, 32'h111, 32'd3, 6'd9, 1'b0, 6'd5, 1'b1);
      cdb_valid = 1'b1; cdb_phys_rd = 6'd9; cdb_data = 32'h42;
      tick(); disp_valid = 1'b0; cdb_valid = 1'b0;
      check("byp_nostart", 32'(issue_start), 0);
      tick();
      check("byp_start", 32'(issue_start), 1);
      check("byp_rs1", issue_uop.rs1_v, 32'h42);
      tick();

      // Fill under stall; outputs hold the last issued op.
      issue_stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_disp(4'(i), 32'(100 + i), 32'd0, 6'd1, 1'b1, 6'd2, 1'b1);
         tick();
      end
      check("full_occ", 32'(occupancy), 8);
      check("full_ready", 32'(disp_ready), 0);
      check("full_hold_start", 32'(issue_start), 0);
      check("full_hold_uop", issue_uop.rs1_v, 32'h42);
      set_disp(4'd15, 32'd999, 32'd0, 6'd1, 1'b1, 6'd2, 1'b1);
      tick(); disp_valid = 1'b0;
      check("ninth_occ", 32'(occupancy), 8);
      check("ninth_hold_uop", issue_uop.rs1_v, 32'h42);
      issue_stall = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("drain_start", 32'(issue_start), 1);
         check("drain_rs1", issue_uop.rs1_v, 32'(100 + i));
         check("drain_op", 32'(issue_uop.op), 32'(i));
      end
      check("drain_occ", 32'(occupancy), 0);
      tick();
      check("drain_idle", 32'(issue_start), 0);

      // Flush with 4 waiting entries while an issue is pending.
      for (int i = 0; i < 4; i++) begin
         set_disp(4'd6, 32'd0, 32'd0, 6'd20, 1'b0, 6'd20, 1'b0);
         tick();
      end
      set_disp(4'd7, 32'h55, 32'd1, 6'd1, 1'b1, 6'd2, 1'b1);
      tick(); disp_valid = 1'b0;
      tick();
      check("pre_flush_start", 32'(issue_start), 1);
      check("pre_flush_occ", 32'(occupancy), 4);
      flush = 1'b1;
      set_disp(4'd8, 32'h77, 32'd1, 6'd1, 1'b1, 6'd2, 1'b1);
      tick(); flush = 1'b0; disp_valid = 1'b0;
      check("flush_occ", 32'(occupancy), 0);
      check("flush_start", 32'(issue_start), 0);
      check("flush_ready", 32'(disp_ready), 1);
      cdb_valid = 1'b1; cdb_phys_rd = 6'd20; cdb_data = 32'h9;
      tick(); cdb_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("flush_no_issue", 32'(issue_start), 0);
      end

      // Tag 0 source is ready with value 0 whatever its rdy bit.
      set_disp(4'd9, 32'hABC, 32'd9, 6'd0, 1'b0, 6'd3, 1'b1);
      tick(); disp_valid = 1'b0;
      tick();
      check("zero_start", 32'(issue_start), 1);
      check("zero_rs1", issue_uop.rs1_v, 0);
      check("zero_rs2", issue_uop.rs2_v, 9);
      tick();

      // Reset mid-stream with 3 waiting entries.
      for (int i = 0; i < 3; i++) begin
         set_disp(4'd10, 32'd0, 32'd0, 6'd30, 1'b0, 6'd2, 1'b1);
         tick();
      end
      disp_valid = 1'b0;
      check("pre_rst_occ", 32'(occupancy), 3);
      rst = 1'b1;
      tick(); rst = 1'b0;
      check("mid_rst_occ", 32'(occupancy), 0);
      check("mid_rst_start", 32'(issue_start), 0);
      check("mid_rst_ready", 32'(disp_ready), 1);
      cdb_valid = 1'b1; cdb_phys_rd = 6'd30; cdb_data = 32'h1;
      tick(); cdb_valid = 1'b0;
      tick();
      check("mid_rst_no_issue", 32'(issue_start), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Holds dispatched integer-ALU micro-ops until both source operands are available.
- Snoops the CDB to wake up waiting operands.
- Issues one ready micro-op per cycle to the ALU functional unit using its start/stall contract.
- Sits between dispatch/rename and the ALU functional unit; the ALU unit's start, stall and functional_unit_t inputs are driven directly from this block.

Parameters:
DEPTH, 8, number of entries (power of 2, at least 2)
PHYS_W, 6, physical register tag width
CNT_W, 4, occupancy counter width, equal to log2(DEPTH)+1

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  mispredict flush; empties the station
disp_valid  in  1  dispatch request
disp_ready  out  1  station can accept a dispatch this cycle
disp_uop  in  functional_unit_t  micro-op payload; rs1_v/rs2_v are meaningful only when the matching ready bit is set
disp_rs1_s  in  PHYS_W  rs1 physical tag
disp_rs2_s  in  PHYS_W  rs2 physical tag
disp_rs1_rdy  in  1  rs1 value is valid in disp_uop.rs1_v
disp_rs2_rdy  in  1  rs2 value is valid in disp_uop.rs2_v
cdb_valid  in  1  CDB broadcast valid
cdb_phys_rd  in  PHYS_W  broadcast destination tag
cdb_data  in  32  broadcast value
issue_stall  in  1  same stall the ALU unit receives
issue_start  out  1  to ALU unit start
issue_uop  out  functional_unit_t  to ALU unit; operand values filled in
occupancy  out  CNT_W  number of valid entries

Behaviour:
- Reset (rst, synchronous, active-high; clock clk):
  - All entry valid bits cleared.
  - issue_start=0, issue_uop='0, occupancy=0.
  - disp_ready=1 in the first cycle after reset.
- Entry contents: valid, payload, rs1_s, rs2_s, rs1_rdy, rs2_rdy.
- disp_ready is combinational: 1 when occupancy < DEPTH, from current-cycle valid bits only.
  - A slot freed by issue at edge N can be used from edge N+1 onward.
- Dispatch: on a clk edge with disp_valid && disp_ready && !flush, write the lowest-index invalid entry.
  - disp_valid while !disp_ready: ignored, no state change.
  - Tag 0: a source with tag 0 is stored ready with value 0, regardless of its rdy bit.
- Wakeup: each edge with cdb_valid and cdb_phys_rd != 0, every valid entry with !rsX_rdy and rsX_s == cdb_phys_rd sets rsX_rdy=1 and captures rsX_v=cdb_data.
  - rs1 and rs2 are checked independently; both may wake in the same cycle.
- Same-cycle bypass: if a dispatching source is not ready and its tag equals a valid CDB tag in that cycle, store it ready with cdb_data.
- Selection: uses registered ready bits only. An entry woken at edge N is first selectable for issue at edge N+1.
  - Candidate: valid && rs1_rdy && rs2_rdy.
  - Priority: lowest index wins.
- Issue, on each edge with !issue_stall:
  - A candidate exists: issue_start<=1, issue_uop<=candidate payload with rs1_v/rs2_v from the entry, entry valid<=0.
  - No candidate: issue_start<=0; issue_uop holds its last value.
- Stall: while issue_stall=1, issue_start and issue_uop hold and no entry is freed.
  - Dispatch and wakeup continue during stall.
- Latency: a dispatched micro-op with both sources ready, into an empty station with no stall, is accepted at edge N and has issue_start=1 after edge N+1.
- occupancy: registered, updated by +1 for dispatch and -1 for issue. Simultaneous dispatch and issue leaves it unchanged.
- Flush: synchronous; priority rst > flush > all other events.
  - Clears all valid bits, issue_start<=0 and occupancy<=0.
  - A dispatch in the same cycle is dropped.
  - Flush overrides issue_stall.
- Full-station corner: an issue and a dispatch in the same cycle when full → dispatch is rejected (disp_ready=0).
- CDB is never back-pressured; this block has no CDB output.

Test Plan:
- Dispatch an ADD with both sources ready (rs1_v=5, rs2_v=7), station empty, no stall → issue_start=1 two edges after disp_valid is asserted, issue_uop.rs1_v=5, rs2_v=7, occupancy returns to 0.
- Dispatch with rs2 tag 12 not ready; CDB broadcasts tag 12, data 0xDEADBEEF, 3 cycles later → issue on the edge after the wakeup edge with rs2_v=0xDEADBEEF; no issue before that.
- Dispatch with rs1 tag 9 not ready in the same cycle the CDB broadcasts tag 9, data 0x42 → stored ready, issues next edge with rs1_v=0x42.
- Fill 8 entries with independent ready ops under issue_stall=1 → disp_ready=0, occupancy=8, a 9th dispatch is ignored, issue_start/issue_uop hold constant.
  - Then drop the stall → entries 0..7 issue in index order, one per cycle.
- With 4 waiting entries and issue_start=1 pending, assert flush for one cycle together with disp_valid → occupancy=0, issue_start=0 next cycle, the dropped op never issues.
- Source tag 0 with disp_rs1_rdy=0 → treated as ready with value 0 and issues without any CDB activity.
- Assert rst mid-stream with 3 entries valid → occupancy=0, issue_start=0, disp_ready=1 after release.
